// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (read-only)
// and the memory stage (read/write), with fixed wait states and per-access done pulses.
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic [DATA_WIDTH-1:0] ifData,
    output logic                  ifDone,
    input  logic                  memReq,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memWData,
    output logic [DATA_WIDTH-1:0] memRData,
    output logic                  memDone,
    output logic [ADDR_WIDTH-1:0] extAddr,
    output logic [DATA_WIDTH-1:0] extWData,
    output logic                  extRE,
    output logic                  extWE,
    input  logic [DATA_WIDTH-1:0] extRData,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t     state;
    state_t     state_next;
    logic       owner;        // 1 = MEM owns the current access, 0 = IF
    logic       last_grant;   // 1 = MEM was granted last
    logic       write;
    logic [3:0] count;
    logic       grant;
    logic       grant_mem;

    // In DONE only the non-owner may be granted, which gives back-to-back service without a bubble.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_mem  = 1'b0;
        case (state)
            IDLE: begin
                if (ifReq || memReq) begin
                    grant     = 1'b1;
                    grant_mem = memReq && (!ifReq || !last_grant);
                end
            end
            ACCESS: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (owner ? ifReq : memReq) begin
                    grant     = 1'b1;
                    grant_mem = !owner;
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant) begin
            state_next = ACCESS;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            write      <= 1'b0;
            count      <= 4'd0;
            extAddr    <= '0;
            extWData   <= '0;
            ifData     <= '0;
            memRData   <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner      <= grant_mem;
                last_grant <= grant_mem;
                write      <= grant_mem && memWrite;
                extAddr    <= grant_mem ? memAddr : ifAddr;
                extWData   <= grant_mem ? memWData : '0;
                count      <= WAIT_INIT;
            end else if (state == ACCESS && count != 4'd0) begin
                count <= count - 4'd1;
            end
            // Read data is valid in the final access cycle only.
            if (state == ACCESS && count == 4'd0 && !write) begin
                if (owner) begin
                    memRData <= extRData;
                end else begin
                    ifData <= extRData;
                end
            end
        end
    end

    assign extRE   = (state == ACCESS) && !write;
    assign extWE   = (state == ACCESS) && write;
    assign ifDone  = (state == DONE) && !owner;
    assign memDone = (state == DONE) && owner;
    assign busy    = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port unified memory between two requesters:
  - the instruction-fetch stage (IF), read-only;
  - the memory stage (MEM), which reads and writes.
- Sits between the control unit's enIF/enMem-driven stages and the external memory.
- Serialises accesses, inserts a fixed number of wait states, and returns one done pulse per access.
- Lets the multi-cycle control unit stall a stage until its access completes.

Parameters:
- DATA_WIDTH, 16, width of memory words and the data buses.
- ADDR_WIDTH, 16, width of memory addresses.
- WAIT_STATES, 2, extra access cycles beyond one; legal range 0..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifReq  in  1  fetch request; held high until ifDone.
- ifAddr  in  ADDR_WIDTH  fetch address; stable while ifReq is high.
- ifData  out  DATA_WIDTH  fetched instruction, registered.
- ifDone  out  1  one-cycle pulse when the fetch completes.
- memReq  in  1  data-access request; held high until memDone.
- memWrite  in  1  1 = store, 0 = load; sampled at grant.
- memAddr  in  ADDR_WIDTH  data address; sampled at grant.
- memWData  in  DATA_WIDTH  store data; sampled at grant.
- memRData  out  DATA_WIDTH  load result, registered.
- memDone  out  1  one-cycle pulse when the data access completes.
- extAddr  out  ADDR_WIDTH  address to the external memory.
- extWData  out  DATA_WIDTH  write data to the external memory.
- extRE  out  1  external read strobe.
- extWE  out  1  external write strobe.
- extRData  in  DATA_WIDTH  external read data; valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and DONE states.

Behaviour:
- Reset values, applied immediately on reset assertion:
  - state = IDLE;
  - all outputs = 0: ifData, memRData, extAddr, extWData, extRE, extWE, ifDone, memDone, busy;
  - lastGrant = MEM, so IF wins the first contention;
  - wait counter = 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is pending, latch the owner, address, write flag and write data, load the counter with WAIT_STATES, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single request is granted.
  - When both are pending, grant the requester that is not lastGrant.
  - lastGrant is updated at each grant.
- ACCESS:
  - extAddr and extWData come from the latched values.
  - extRE = !write and extWE = write, asserted every ACCESS cycle.
  - The counter decrements each cycle.
  - When the counter == 0:
    - on a read, capture extRData into ifData or memRData according to the owner;
    - go to DONE.
  - ACCESS lasts exactly WAIT_STATES+1 cycles.
- DONE:
  - The owner's done output is high for exactly this one cycle.
  - extRE and extWE are 0.
  - The owner's req is ignored in this cycle.
  - If the other requester is pending, grant it directly (DONE→ACCESS, no IDLE bubble). Otherwise go to IDLE.
- Latency:
  - Request sampled at edge k → ACCESS during cycles k+1..k+1+WAIT_STATES → done during cycle k+2+WAIT_STATES.
  - Total: WAIT_STATES+2 cycles.
- Read registers:
  - ifData and memRData hold their value until the next completed read for the same port.
  - Stores never modify memRData.
- No preemption. A request arriving mid-access waits; its maximum wait is one full access plus its own.
- A request deasserted before its done pulse is a protocol violation; behaviour is undefined, but the FSM must still return to IDLE.
- Reset mid-access:
  - strobes drop at once and the access is abandoned;
  - no done pulse is produced;
  - requesters must re-request after reset.
- Widths: addresses and data pass through unmodified. The counter is 4 bits.

Test Plan:
- IF only, WAIT_STATES=2:
  - Stimulus: ifReq=1, ifAddr=0x0010, extRData=0xA5A5.
  - Required: extRE high for 3 cycles, extWE=0, ifDone pulses 4 cycles after the request is sampled, ifData=0xA5A5, memRData=0.
- Store:
  - Stimulus: memReq=1, memWrite=1, memAddr=0x0200, memWData=0x1234.
  - Required: extWE high for 3 cycles with extAddr=0x0200 and extWData=0x1234, extRE=0, memDone pulses once, memRData unchanged.
- Contention after reset:
  - Stimulus: ifReq and memReq rise in the same cycle.
  - Required: IF is served first, then MEM is granted straight from DONE without an IDLE cycle. ifDone and memDone are 4 cycles apart.
- Round robin:
  - Stimulus: ifReq and memReq both held high continuously over 4 accesses, WAIT_STATES=0.
  - Required: grants alternate IF, MEM, IF, MEM; each done occurs 2 cycles apart; no done pulse lasts more than 1 cycle.
- Reset mid-access:
  - Stimulus: assert reset in the second ACCESS cycle of a load.
  - Required: extRE=0 immediately, no memDone, busy=0, memRData=0. After release with memReq held, a fresh full-latency access completes.
